// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks (uart_tx, uart_bytes_tx, uart_rx,
// uart_bytes_rx).
//   - uart_state_t    : byte-level FSM state encoding (IDLE/START/DATA/STOP)
//   - UART_DATA_BITS  : data bits per character
//   - calc_baud_cnt   : system clock cycles per bit period
//   - calc_cnt_width  : counter width able to hold 0..max_val
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int UART_DATA_BITS = 8;

  // Integer division: any fractional cycle is dropped.
  function automatic int calc_baud_cnt(input int clk_fre, input int bps);
    return clk_fre / bps;
  endfunction

  // Never returns less than 1 so the result can always size a vector.
  function automatic int calc_cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Single-character UART receiver: 1 start, 8 data (LSB first), 1 stop, no
// parity. The line is brought into the sys_clk domain by a 2-flop
// synchronizer; every decision is taken on the synchronized value.
// Ports:
//   sys_clk      in   system clock, rising edge
//   sys_rst_n    in   asynchronous active-low reset
//   uart_rxd     in   asynchronous serial line, idle high
//   uart_rx_data out  last correctly framed character (held)
//   uart_rx_done out  one-cycle pulse, good stop bit, uart_rx_data updated
//   uart_rx_err  out  one-cycle pulse, stop bit sampled low (character dropped)
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int BPS     = 115200,
  parameter int CLK_FRE = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_done,
  output logic       uart_rx_err
);

  localparam int BAUD_CNT = calc_baud_cnt(CLK_FRE, BPS);
  localparam int HALF_CNT = BAUD_CNT / 2;
  localparam int CNT_W    = calc_cnt_width(BAUD_CNT);

  localparam logic [CNT_W-1:0] C_BAUD_LAST = CNT_W'(BAUD_CNT - 1);
  localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(HALF_CNT - 1);

  logic              r_rxd_meta;
  logic              r_rxd_sync;
  logic              r_rxd_prev;
  logic              w_rxd_fall;

  uart_state_t       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic [7:0]        r_data;
  logic              r_done;
  logic              r_err;

  // Synchronizer plus one history flop for edge detection; all reset to the
  // idle level so a reset release never looks like a start edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_rxd_meta <= uart_rxd;
      r_rxd_sync <= r_rxd_meta;
      r_rxd_prev <= r_rxd_sync;
    end
  end

  assign w_rxd_fall = r_rxd_prev & ~r_rxd_sync;

  // Byte FSM. Samples are taken half a bit after the start edge and then
  // once per bit period, so every sample sits at mid-bit. The FSM leaves STOP
  // at the mid-bit sample so a start edge in the second half of the stop bit
  // is still seen in IDLE.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_data    <= 8'h00;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= 3'd0;
          if (w_rxd_fall) begin
            r_state <= ST_START;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_START: begin
          if (r_cnt == C_HALF_LAST) begin
            r_cnt <= '0;
            // Line back high at mid start bit: glitch, drop silently.
            if (r_rxd_sync) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_DATA;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (r_cnt == C_BAUD_LAST) begin
            r_cnt     <= '0;
            r_shift   <= {r_rxd_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
            end else begin
              r_state <= ST_DATA;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (r_cnt == C_BAUD_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            if (r_rxd_sync) begin
              r_data <= r_shift;
              r_done <= 1'b1;
            end else begin
              r_err  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign uart_rx_data = r_data;
  assign uart_rx_done = r_done;
  assign uart_rx_err  = r_err;

endmodule

// File: rtl/uart_bytes_rx.sv
// -----------------------------------------------------------------------------
// uart_bytes_rx
// Receives frames of BYTES characters over a UART line and presents each
// complete frame as one word. The first character received lands in the low
// byte (same ordering as uart_bytes_tx). A bad stop bit or an inter-byte gap
// longer than TIMEOUT_BITS bit periods throws the partial frame away.
// Ports:
//   sys_clk          in   system clock, rising edge
//   sys_rst_n        in   asynchronous active-low reset
//   uart_rxd         in   asynchronous serial line, idle high
//   uart_bytes_data  out  last complete frame, held between completions
//   uart_bytes_done  out  one-cycle pulse when uart_bytes_data is updated
//   uart_bytes_err   out  one-cycle pulse when a partial frame is discarded
// -----------------------------------------------------------------------------
module uart_bytes_rx
  import uart_pkg::*;
#(
  parameter int BYTES        = 8,
  parameter int BPS          = 115200,
  parameter int CLK_FRE      = 50_000_000,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               uart_rxd,
  output logic [BYTES*8-1:0] uart_bytes_data,
  output logic               uart_bytes_done,
  output logic               uart_bytes_err
);

  localparam int BAUD_CNT    = calc_baud_cnt(CLK_FRE, BPS);
  localparam int TIMEOUT_CNT = TIMEOUT_BITS * BAUD_CNT;
  localparam int TO_W        = calc_cnt_width(TIMEOUT_CNT);
  localparam int BC_W        = calc_cnt_width(BYTES - 1);

  localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT_CNT - 1);
  localparam logic [BC_W-1:0] C_BC_LAST = BC_W'(BYTES - 1);

  logic [7:0]         w_rx_data;
  logic               w_rx_done;
  logic               w_rx_err;
  logic [BYTES*8-1:0] w_frame_next;

  logic [BYTES*8-1:0] r_frame;
  logic [BC_W-1:0]    r_byte_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic [BYTES*8-1:0] r_data;
  logic               r_done;
  logic               r_err;

  uart_rx #(
    .BPS     (BPS),
    .CLK_FRE (CLK_FRE)
  ) u_uart_rx (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .uart_rxd     (uart_rxd),
    .uart_rx_data (w_rx_data),
    .uart_rx_done (w_rx_done),
    .uart_rx_err  (w_rx_err)
  );

  // Assembly shifts toward the low byte and inserts the new character at the
  // top; after BYTES characters the first one has reached bits [7:0].
  always_comb begin
    w_frame_next = r_frame;
    for (int i = 0; i < BYTES - 1; i++) begin
      w_frame_next[i*8 +: 8] = r_frame[(i+1)*8 +: 8];
    end
    w_frame_next[(BYTES-1)*8 +: 8] = w_rx_data;
  end

  // Frame assembly, byte counter and idle timeout. Branch order encodes the
  // priorities: a byte-done beats a timeout expiring in the same cycle, and
  // done/err are produced by mutually exclusive branches.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_frame    <= '0;
      r_byte_cnt <= '0;
      r_to_cnt   <= '0;
      r_data     <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_rx_done) begin
        r_to_cnt <= '0;
        if (r_byte_cnt == C_BC_LAST) begin
          r_data     <= w_frame_next;
          r_done     <= 1'b1;
          r_byte_cnt <= '0;
          r_frame    <= '0;
        end else begin
          r_frame    <= w_frame_next;
          r_byte_cnt <= r_byte_cnt + BC_W'(1);
        end
      end else if (w_rx_err) begin
        r_frame    <= '0;
        r_byte_cnt <= '0;
        r_to_cnt   <= '0;
        r_err      <= 1'b1;
      end else if (r_byte_cnt == BC_W'(0)) begin
        // No frame in progress: the timeout is parked.
        r_to_cnt <= '0;
      end else if (r_to_cnt == C_TO_LAST) begin
        r_frame    <= '0;
        r_byte_cnt <= '0;
        r_to_cnt   <= '0;
        r_err      <= 1'b1;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

  assign uart_bytes_data = r_data;
  assign uart_bytes_done = r_done;
  assign uart_bytes_err  = r_err;

endmodule

// File: tb/tb_uart_bytes_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_bytes_rx
// Self-checking bench for uart_bytes_rx with BYTES=4. The baud rate is raised
// to give 64 clocks per bit so the whole run stays short; the glitch length is
// scaled to the same fraction of a bit. Expected frames are queued when sent
// and popped by a monitor on every done pulse.
// -----------------------------------------------------------------------------
module tb_uart_bytes_rx;

  localparam int BYTES        = 4;
  localparam int BPS          = 781_250;
  localparam int CLK_FRE      = 50_000_000;
  localparam int TIMEOUT_BITS = 20;
  localparam int B            = CLK_FRE / BPS;   // 64 cycles per bit

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        uart_rxd  = 1'b1;
  logic [31:0] uart_bytes_data;
  logic        uart_bytes_done;
  logic        uart_bytes_err;

  int          checks       = 0;
  int          errors       = 0;
  int          cyc          = 0;
  int          done_seen    = 0;
  int          err_seen     = 0;
  int          last_err_cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_exp;

  uart_bytes_rx #(
    .BYTES        (BYTES),
    .BPS          (BPS),
    .CLK_FRE      (CLK_FRE),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .uart_rxd        (uart_rxd),
    .uart_bytes_data (uart_bytes_data),
    .uart_bytes_done (uart_bytes_done),
    .uart_bytes_err  (uart_bytes_err)
  );

  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor: exclusivity of done/err and scoreboard on every done pulse.
  always @(negedge sys_clk) begin
    if (uart_bytes_done || uart_bytes_err) begin
      checks++;
      if (uart_bytes_done && uart_bytes_err) begin
        errors++;
        $display("FAIL excl: done=1 err=1 at cycle %0d, required not both", cyc);
      end
    end
    if (uart_bytes_err) begin
      err_seen++;
      last_err_cyc = cyc;
    end
    if (uart_bytes_done) begin
      done_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_data: unexpected done with data %h, no frame queued", uart_bytes_data);
      end else begin
        m_exp = exp_q.pop_front();
        if (uart_bytes_data !== m_exp) begin
          errors++;
          $display("FAIL frame_data: got %h expected %h", uart_bytes_data, m_exp);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic idle_bits(input int n);
    uart_rxd = 1'b1;
    wait_cyc(n * B);
  endtask

  // Line is left at the stop level so the next call can start immediately.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    wait_cyc(B);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      wait_cyc(B);
    end
    uart_rxd = stop_bit;
    wait_cyc(B);
  endtask

  task automatic send_frame(input logic [31:0] w);
    exp_q.push_back(w);
    for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8], 1'b1);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    wait_cyc(5);
    checks += 3;
    if (uart_bytes_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", uart_bytes_data); end
    if (uart_bytes_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", uart_bytes_done); end
    if (uart_bytes_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", uart_bytes_err); end
    sys_rst_n = 1'b1;
    wait_cyc(20);
    checks += 2;
    if (done_seen !== 0) begin errors++; $display("FAIL rst_release_done: got %0d pulses expected 0", done_seen); end
    if (err_seen !== 0) begin errors++; $display("FAIL rst_release_err: got %0d pulses expected 0", err_seen); end
  endtask

  task automatic test_back_to_back();
    int d0 = done_seen;
    int e0 = err_seen;
    exp_q.push_back(32'h12345678);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    idle_bits(2);
    checks += 3;
    if (done_seen - d0 !== 1) begin errors++; $display("FAIL b2b_done: got %0d pulses expected 1", done_seen - d0); end
    if (err_seen - e0 !== 0) begin errors++; $display("FAIL b2b_err: got %0d pulses expected 0", err_seen - e0); end
    if (uart_bytes_data !== 32'h12345678) begin errors++; $display("FAIL b2b_hold: got %h expected 12345678", uart_bytes_data); end
  endtask

  task automatic test_timeout();
    int d0 = done_seen;
    int e0 = err_seen;
    int t_stop;
    int rel;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    t_stop = cyc;
    idle_bits(25);
    rel = last_err_cyc - t_stop;
    checks += 4;
    if (err_seen - e0 !== 1) begin errors++; $display("FAIL to_err: got %0d pulses expected 1", err_seen - e0); end
    if (rel < 19 * B || rel > 21 * B) begin errors++; $display("FAIL to_time: err %0d cycles after stop, expected %0d..%0d", rel, 19 * B, 21 * B); end
    if (done_seen - d0 !== 0) begin errors++; $display("FAIL to_nodone: got %0d pulses expected 0", done_seen - d0); end
    if (uart_bytes_data !== 32'h12345678) begin errors++; $display("FAIL to_hold: got %h expected 12345678", uart_bytes_data); end
    send_frame(32'hAABBCCDD);
    idle_bits(2);
    checks += 2;
    if (done_seen - d0 !== 1) begin errors++; $display("FAIL to_after_done: got %0d pulses expected 1", done_seen - d0); end
    if (err_seen - e0 !== 1) begin errors++; $display("FAIL to_after_err: got %0d pulses expected 1", err_seen - e0); end
  endtask

  task automatic test_stop_error();
    int d0 = done_seen;
    int e0 = err_seen;
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b0);
    idle_bits(2);
    checks += 3;
    if (err_seen - e0 !== 1) begin errors++; $display("FAIL stop_err: got %0d pulses expected 1", err_seen - e0); end
    if (done_seen - d0 !== 0) begin errors++; $display("FAIL stop_nodone: got %0d pulses expected 0", done_seen - d0); end
    if (uart_bytes_data !== 32'hAABBCCDD) begin errors++; $display("FAIL stop_hold: got %h expected aabbccdd", uart_bytes_data); end
    send_frame(32'h01020304);
    idle_bits(2);
    checks += 2;
    if (done_seen - d0 !== 1) begin errors++; $display("FAIL stop_after_done: got %0d pulses expected 1", done_seen - d0); end
    if (err_seen - e0 !== 1) begin errors++; $display("FAIL stop_after_err: got %0d pulses expected 1", err_seen - e0); end
  endtask

  task automatic test_glitch();
    int d0 = done_seen;
    int e0 = err_seen;
    uart_rxd = 1'b0;
    wait_cyc(B / 4);
    idle_bits(3);
    checks += 2;
    if (done_seen - d0 !== 0) begin errors++; $display("FAIL glitch_done: got %0d pulses expected 0", done_seen - d0); end
    if (err_seen - e0 !== 0) begin errors++; $display("FAIL glitch_err: got %0d pulses expected 0", err_seen - e0); end
    send_frame(32'h5A3C96E1);
    idle_bits(2);
    checks += 2;
    if (done_seen - d0 !== 1) begin errors++; $display("FAIL glitch_frame_done: got %0d pulses expected 1", done_seen - d0); end
    if (err_seen - e0 !== 0) begin errors++; $display("FAIL glitch_frame_err: got %0d pulses expected 0", err_seen - e0); end
  endtask

  task automatic test_reset_mid_frame();
    int d0 = done_seen;
    int e0 = err_seen;
    logic [7:0] b3 = 8'hAD;
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    uart_rxd = 1'b0;
    wait_cyc(B);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = b3[i];
      wait_cyc(B);
    end
    uart_rxd = b3[4];
    wait_cyc(B / 2);
    sys_rst_n = 1'b0;
    wait_cyc(3);
    checks += 3;
    if (uart_bytes_data !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h expected 0", uart_bytes_data); end
    if (uart_bytes_done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", uart_bytes_done); end
    if (uart_bytes_err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b expected 0", uart_bytes_err); end
    uart_rxd = 1'b1;
    wait_cyc(5);
    sys_rst_n = 1'b1;
    idle_bits(2);
    send_frame(32'hCAFEBABE);
    idle_bits(2);
    checks += 3;
    if (done_seen - d0 !== 1) begin errors++; $display("FAIL midrst_frame_done: got %0d pulses expected 1", done_seen - d0); end
    if (err_seen - e0 !== 0) begin errors++; $display("FAIL midrst_frame_err: got %0d pulses expected 0", err_seen - e0); end
    if (uart_bytes_data !== 32'hCAFEBABE) begin errors++; $display("FAIL midrst_hold: got %h expected cafebabe", uart_bytes_data); end
  endtask

  task automatic test_loopback();
    int d0 = done_seen;
    int e0 = err_seen;
    logic [31:0] w;
    for (int f = 0; f < 3; f++) begin
      w = $urandom;
      send_frame(w);
    end
    idle_bits(2);
    checks += 3;
    if (done_seen - d0 !== 3) begin errors++; $display("FAIL loop_done: got %0d pulses expected 3", done_seen - d0); end
    if (err_seen - e0 !== 0) begin errors++; $display("FAIL loop_err: got %0d pulses expected 0", err_seen - e0); end
    if (exp_q.size() !== 0) begin errors++; $display("FAIL loop_queue: %0d frames outstanding, expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_timeout();
    test_stop_error();
    test_glitch();
    test_reset_mid_frame();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_bytes_rx.md
UART_BYTES_RX -- requirements
Module: uart_bytes_rx

Interface
REQ-001 SHALL have parameter BYTES, default 8: bytes per frame, 8 bits each.
REQ-002 SHALL have parameter BPS, default 115200: receive baud rate.
REQ-003 SHALL have parameter CLK_FRE, default 50_000_000: sys_clk frequency in Hz.
REQ-004 SHALL have parameter TIMEOUT_BITS, default 20: maximum idle gap between bytes of one frame, in bit periods.
REQ-005 SHALL have port sys_clk, input, 1: system clock, all logic on rising edge.
REQ-006 SHALL have port sys_rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port uart_rxd, input, 1: asynchronous UART receive line, idle high.
REQ-008 SHALL have port uart_bytes_data, output, BYTES*8: last complete received frame.
REQ-009 SHALL have port uart_bytes_done, output, 1: one-cycle pulse when uart_bytes_data is updated.
REQ-010 SHALL have port uart_bytes_err, output, 1: one-cycle pulse when a partial frame is discarded.

Function
REQ-011 SHALL use line format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-012 SHALL define BAUD_CNT = CLK_FRE/BPS (integer division); one bit period = BAUD_CNT cycles.
REQ-013 SHALL pass uart_rxd through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-014 SHALL use byte FSM states IDLE, START, DATA, STOP.
- IDLE -> START on a falling edge of the synchronized line.
REQ-015 In START, SHALL sample at BAUD_CNT/2 cycles.
- Line high at sample: false start, return to IDLE, no output of any kind.
- Line low: go to DATA.
REQ-016 In DATA, SHALL sample each bit BAUD_CNT cycles after the previous sample and shift it in LSB first; go to STOP after bit 7.
REQ-017 In STOP, SHALL sample mid-bit, then return to IDLE immediately so a start edge in the second half of the stop bit is still caught.
- Sample = 1: byte-done.
- Sample = 0: byte-error.
REQ-018 SHALL assemble a frame little-endian: first received byte lands in uart_bytes_data[7:0], last in the top byte (matches uart_bytes_tx ordering).
REQ-019 SHALL keep a byte counter (0..BYTES-1).
- Each byte-done increments it.
- On byte-done with counter = BYTES-1: copy assembled word to uart_bytes_data, pulse uart_bytes_done in the same cycle, clear the counter.
REQ-020 uart_bytes_data SHALL hold its value between completions and never show partial frames.
REQ-021 On byte-error, SHALL clear the counter, discard the partial frame, pulse uart_bytes_err for one cycle and drop that byte; no done pulse.
REQ-022 SHALL run an idle timeout while counter ≠ 0:
- Counter cleared by every byte-done, and held at 0 when the byte counter = 0.
- Reaching TIMEOUT_BITS*BAUD_CNT cycles clears the byte counter and pulses uart_bytes_err once.
REQ-023 If the timeout and a byte-done occur in the same cycle, byte-done SHALL win and no error is flagged.
REQ-024 uart_bytes_done and uart_bytes_err SHALL never both be high in the same cycle.
REQ-025 SHALL accept back-to-back bytes and frames with zero idle time between stop and next start, with no loss.

Reset
REQ-026 While sys_rst_n is low, SHALL hold all state at reset values:
- FSM in IDLE; all counters and the shift register 0.
- uart_bytes_data = 0, uart_bytes_done = 0, uart_bytes_err = 0.
- Synchronizer flops = 1.
REQ-027 Reset asserted mid-byte or mid-frame SHALL discard all partial data. After release, reception SHALL restart only on the next falling edge.

Structure
REQ-028 SHALL instantiate one sub-module uart_rx containing the synchronizer and byte FSM.
- Inputs: sys_clk, sys_rst_n, uart_rxd.
- Outputs: uart_rx_data[7:0], uart_rx_done, uart_rx_err.
- Parameters: BPS, CLK_FRE.
REQ-029 SHALL place BAUD_CNT computation and FSM state encodings in the shared uart package used by uart_tx/uart_bytes_tx. Frame assembly, byte counter and timeout stay in uart_bytes_rx.

Verification (BYTES=4, BPS=115200, CLK_FRE=50_000_000, BAUD_CNT=434)
REQ-030 Send 0x78,0x56,0x34,0x12 back-to-back -> exactly one uart_bytes_done pulse; uart_bytes_data = 0x12345678; uart_bytes_err never high.
REQ-031 Send 0x11,0x22, idle 25 bit periods, then 0xDD,0xCC,0xBB,0xAA -> one err pulse about 20 bit periods after the 0x22 stop bit; then done with 0xAABBCCDD.
REQ-032 Send 0x01, then 0x02 with stop bit driven 0, then 0x04,0x03,0x02,0x01 -> one err pulse on the bad byte, no done; then done with 0x01020304.
REQ-033 Drive a 100-cycle low glitch on idle uart_rxd, then send one valid frame -> glitch produces no output; frame received correctly.
REQ-034 Assert sys_rst_n low during bit 4 of the 3rd byte, release, send a full frame 0xCAFEBABE (little-endian) -> outputs 0 during reset; then a single done with 0xCAFEBABE.
REQ-035 Send the uart_bytes_tx output loopback for 3 consecutive frames -> three done pulses with data matching the transmitted words.
